// File: rtl/syn_audio_pkg.sv
// Shared audio types: PCM resolution, stereo sample layout and the
// capture-FSM state encoding.
package syn_audio_pkg;

  localparam int P_PCM_RES   = 16;
  localparam int P_BIT_CNT_W = $clog2(P_PCM_RES);

  // One stereo sample; lchnl occupies the upper half of the packed word.
  typedef struct packed {
    logic signed [P_PCM_RES-1:0] lchnl;
    logic signed [P_PCM_RES-1:0] rchnl;
  } pcm_data_t;

  typedef enum logic [2:0] {
    CAP_IDLE    = 3'd0,
    CAP_L_SKIP  = 3'd1,
    CAP_L_SHIFT = 3'd2,
    CAP_R_WAIT  = 3'd3,
    CAP_R_SKIP  = 3'd4,
    CAP_R_SHIFT = 3'd5,
    CAP_L_WAIT  = 3'd6
  } adc_cap_fsm_t;

endpackage

// File: rtl/syn_pcm_xfr_intf.sv
// PCM sample transfer between a producer (master) and a consumer (slave).
// Handshake: the master raises pcm_data_valid with pcm_data and holds both
// stable until it samples ack=1 on a clock edge; that edge retires the
// sample. ack while pcm_data_valid=0 has no effect.
interface syn_pcm_xfr_intf;
  import syn_audio_pkg::*;

  logic      pcm_data_valid;
  pcm_data_t pcm_data;
  logic      ack;

  modport master (output pcm_data_valid, output pcm_data, input ack);
  modport slave  (input pcm_data_valid, input pcm_data, output ack);
endinterface

// File: rtl/syn_edge_sync.sv
// N-flop synchroniser for an asynchronous level, with single-cycle
// rise/fall pulses derived from the synchronised value.
module syn_edge_sync #(
  parameter int P_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [P_STAGES-1:0] sync_r;
  logic                q_prev;

  // Shift the raw input through the synchroniser chain and remember the
  // previous synchronised value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      q_prev <= 1'b0;
    end else begin
      sync_r <= {sync_r[P_STAGES-2:0], d};
      q_prev <= sync_r[P_STAGES-1];
    end
  end

  assign q    = sync_r[P_STAGES-1];
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/syn_adc_cap.sv
// I2S capture from the codec ADC: assembles one stereo PCM sample per
// frame, offers it on pcm_xfr and counts frames lost to a slow consumer.
module syn_adc_cap
  import syn_audio_pkg::*;
#(
  parameter int P_SYNC_STAGES = 2,
  parameter int P_OVFL_CNT_W  = 8
) (
  input  logic                    clk_ir,
  input  logic                    rst_il,
  input  logic                    cap_en,
  input  logic                    bclk,
  input  logic                    adc_lrc,
  input  logic                    adc_dat,
  syn_pcm_xfr_intf.master         pcm_xfr,
  output logic [P_OVFL_CNT_W-1:0] ovfl_cnt,
  output logic                    ovfl_sticky,
  output adc_cap_fsm_t            fsm_state
);

  localparam logic [P_BIT_CNT_W-1:0] LAST_BIT = P_BIT_CNT_W'(P_PCM_RES - 1);

  logic bre;
  logic lrc_s;
  logic dat_s;
  logic unused_bclk_lvl, unused_bclk_fall;
  logic unused_lrc_rise, unused_lrc_fall;
  logic unused_dat_rise, unused_dat_fall;

  syn_edge_sync #(.P_STAGES(P_SYNC_STAGES)) u_bclk_sync (
    .clk(clk_ir), .rst(rst_il), .d(bclk),
    .q(unused_bclk_lvl), .rise(bre), .fall(unused_bclk_fall)
  );

  syn_edge_sync #(.P_STAGES(P_SYNC_STAGES)) u_lrc_sync (
    .clk(clk_ir), .rst(rst_il), .d(adc_lrc),
    .q(lrc_s), .rise(unused_lrc_rise), .fall(unused_lrc_fall)
  );

  syn_edge_sync #(.P_STAGES(P_SYNC_STAGES)) u_dat_sync (
    .clk(clk_ir), .rst(rst_il), .d(adc_dat),
    .q(dat_s), .rise(unused_dat_rise), .fall(unused_dat_fall)
  );

  // lrc is judged only at bit-clock rising edges, against its value at the
  // previous one, so a transition is tied to a specific bit slot.
  logic                   lrc_bre_q;
  logic                   lrc_chg, lrc_fall_bre, lrc_rise_bre;
  logic [P_PCM_RES-1:0]   lsh, rsh, rsh_next;
  logic [P_BIT_CNT_W-1:0] bit_cnt;
  logic                   frame_done;

  assign lrc_chg      = bre && (lrc_s != lrc_bre_q);
  assign lrc_fall_bre = lrc_chg && !lrc_s;
  assign lrc_rise_bre = lrc_chg &&  lrc_s;
  assign rsh_next     = {rsh[P_PCM_RES-2:0], dat_s};

  // Last right bit shifted cleanly: the completed sample is {lsh, rsh_next}.
  assign frame_done = cap_en && bre && !lrc_chg &&
                      (fsm_state == CAP_R_SHIFT) && (bit_cnt == LAST_BIT);

  // Frame-alignment FSM and serial shift registers.
  always_ff @(posedge clk_ir) begin
    if (rst_il) begin
      fsm_state <= CAP_IDLE;
      bit_cnt   <= '0;
      lsh       <= '0;
      rsh       <= '0;
      lrc_bre_q <= 1'b0;
    end else begin
      if (bre) lrc_bre_q <= lrc_s;
      if (!cap_en) begin
        fsm_state <= CAP_IDLE;
        bit_cnt   <= '0;
      end else if (bre) begin
        case (fsm_state)
          CAP_IDLE, CAP_L_WAIT: begin
            if (lrc_fall_bre) fsm_state <= CAP_L_SKIP;
          end
          CAP_L_SKIP: begin
            if (lrc_chg) fsm_state <= CAP_IDLE;
            else begin
              fsm_state <= CAP_L_SHIFT;
              bit_cnt   <= '0;
            end
          end
          CAP_L_SHIFT: begin
            if (lrc_chg) fsm_state <= CAP_IDLE;
            else begin
              lsh <= {lsh[P_PCM_RES-2:0], dat_s};
              if (bit_cnt == LAST_BIT) fsm_state <= CAP_R_WAIT;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end
          CAP_R_WAIT: begin
            if (lrc_rise_bre) fsm_state <= CAP_R_SKIP;
          end
          CAP_R_SKIP: begin
            if (lrc_chg) fsm_state <= CAP_IDLE;
            else begin
              fsm_state <= CAP_R_SHIFT;
              bit_cnt   <= '0;
            end
          end
          CAP_R_SHIFT: begin
            if (lrc_chg) fsm_state <= CAP_IDLE;
            else begin
              rsh <= rsh_next;
              if (bit_cnt == LAST_BIT) fsm_state <= CAP_L_WAIT;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: fsm_state <= CAP_IDLE;
        endcase
      end
    end
  end

  // Output holding register, handshake and dropped-frame accounting.
  always_ff @(posedge clk_ir) begin
    if (rst_il) begin
      pcm_xfr.pcm_data_valid <= 1'b0;
      pcm_xfr.pcm_data       <= '0;
      ovfl_cnt               <= '0;
      ovfl_sticky            <= 1'b0;
    end else if (frame_done) begin
      if (!pcm_xfr.pcm_data_valid || pcm_xfr.ack) begin
        pcm_xfr.pcm_data       <= pcm_data_t'({lsh, rsh_next});
        pcm_xfr.pcm_data_valid <= 1'b1;
      end else begin
        if (ovfl_cnt != '1) ovfl_cnt <= ovfl_cnt + P_OVFL_CNT_W'(1);
        ovfl_sticky <= 1'b1;
      end
    end else if (pcm_xfr.pcm_data_valid && pcm_xfr.ack) begin
      pcm_xfr.pcm_data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_syn_adc_cap.sv
// Bench for syn_adc_cap: drives I2S frames bit by bit, models the expected
// sample stream and overflow accounting at frame level.
module tb_syn_adc_cap;
  import syn_audio_pkg::*;

  localparam int P_SYNC_STAGES = 2;
  localparam int P_OVFL_CNT_W  = 8;
  localparam int OVFL_MAX      = (1 << P_OVFL_CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cap_en = 1'b0;
  logic bclk = 1'b0;
  logic lrc = 1'b1;
  logic dat = 1'b0;
  logic ack_cons = 1'b0;
  logic ack_coinc = 1'b0;
  logic [P_OVFL_CNT_W-1:0] ovfl_cnt;
  logic                    ovfl_sticky;
  adc_cap_fsm_t            fsm_state;

  syn_pcm_xfr_intf pcm_if ();
  assign pcm_if.ack = ack_cons | ack_coinc;

  syn_adc_cap #(.P_SYNC_STAGES(P_SYNC_STAGES), .P_OVFL_CNT_W(P_OVFL_CNT_W)) dut (
    .clk_ir(clk), .rst_il(rst), .cap_en(cap_en), .bclk(bclk),
    .adc_lrc(lrc), .adc_dat(dat), .pcm_xfr(pcm_if),
    .ovfl_cnt(ovfl_cnt), .ovfl_sticky(ovfl_sticky), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] exp_q[$];     // samples the consumer must receive, in order
  bit          mdl_hold = 0; // a sample is sitting unacked (stalled consumer)
  int          mdl_ovfl = 0;
  bit          mdl_sticky = 0;
  int          cons_mode = 1; // 0: consumer acks after ack_dly, 1: never acks
  int          ack_dly = 3;
  int          wcnt = 0;

  logic [31:0] cur_word;
  bit          cur_capt;
  bit          cur_coinc;

  // ---------------- consumer / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (ack_cons) begin
        check("valid_after_ack", pcm_if.pcm_data_valid, 0);
        ack_cons = 1'b0;
        wcnt = 0;
      end else if (pcm_if.pcm_data_valid && cons_mode == 0) begin
        wcnt++;
        if (wcnt >= ack_dly) begin
          if (exp_q.size() == 0) check("unexpected_pcm", 1, 0);
          else check("pcm_data", pcm_if.pcm_data, exp_q.pop_front());
          ack_cons = 1'b1;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic bit_val(input logic [15:0] w, input int p, input bit fill);
    // slot bit 0 carries the lrc change, bit 1 is the I2S delay bit,
    // bits 2..17 are the word MSB first, the rest are don't-care
    if (p >= 2 && p <= 17) return w[17-p];
    if (fill) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Model decision and cycle-exact output checks around the last right bit.
  task automatic finish_frame();
    @(negedge clk);
    @(negedge clk);
    if (cur_coinc) begin
      check("coinc_valid_pre", pcm_if.pcm_data_valid, 1);
      if (exp_q.size() == 0) check("coinc_old_missing", 1, 0);
      else check("coinc_old_data", pcm_if.pcm_data, exp_q.pop_front());
      ack_coinc = 1'b1;
    end else begin
      check("valid_pre_done", pcm_if.pcm_data_valid, 32'(mdl_hold));
    end
    @(negedge clk);
    if (cur_coinc) begin
      ack_coinc = 1'b0;
      check("coinc_valid_post", pcm_if.pcm_data_valid, 1);
      check("coinc_new_data", pcm_if.pcm_data, cur_word);
      exp_q.push_back(cur_word);
    end else if (cur_capt) begin
      if (!mdl_hold) begin
        exp_q.push_back(cur_word);
        if (cons_mode == 1) mdl_hold = 1;
        check("valid_latency", pcm_if.pcm_data_valid, 1);
        check("new_data", pcm_if.pcm_data, cur_word);
      end else begin
        if (mdl_ovfl < OVFL_MAX) mdl_ovfl++;
        mdl_sticky = 1;
        check("held_valid", pcm_if.pcm_data_valid, 1);
        check("held_data", pcm_if.pcm_data, exp_q[0]);
      end
    end else begin
      check("no_output", pcm_if.pcm_data_valid, 32'(mdl_hold));
    end
  endtask

  task automatic send_bit(input logic l, input logic d, input bit fin);
    @(negedge clk);
    bclk = 1'b0;
    lrc  = l;
    dat  = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    if (fin) finish_frame();
    else repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", pcm_if.pcm_data_valid, 0);
    check("rst_data", pcm_if.pcm_data, 0);
    check("rst_ovfl", 32'(ovfl_cnt), 0);
    check("rst_sticky", ovfl_sticky, 0);
    exp_q.delete();
    mdl_hold = 0;
    mdl_ovfl = 0;
    mdl_sticky = 0;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // ev_kind: 0 none, 1 early lrc toggle, 2 cap_en drop, 3 reset (left slot, at ev_pos)
  task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw, input int slot,
                            input int ev_kind, input int ev_pos, input bit fill, input bit coinc);
    cur_word  = {lw, rw};
    cur_capt  = (ev_kind == 0);
    cur_coinc = coinc;
    for (int p = 0; p < slot; p++) begin
      if (p == ev_pos && ev_kind == 2) cap_en = 1'b0;
      if (p == ev_pos && ev_kind == 3) do_reset();
      send_bit((ev_kind == 1 && p >= ev_pos) ? 1'b1 : 1'b0, bit_val(lw, p, fill), 1'b0);
    end
    for (int p = 0; p < slot; p++) begin
      if (p == 0 && ev_kind == 2) cap_en = 1'b1;
      send_bit(1'b1, bit_val(rw, p, fill), p == 17);
    end
  endtask

  task automatic drain_and_check(input string tag);
    repeat (20) @(negedge clk);
    check({tag, "_exp_q_empty"}, exp_q.size(), 0);
    check({tag, "_ovfl"}, 32'(ovfl_cnt), mdl_ovfl);
    check({tag, "_sticky"}, ovfl_sticky, 32'(mdl_sticky));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    n_checks++;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", pcm_if.pcm_data_valid, 0);
    check("reset_data", pcm_if.pcm_data, 0);
    check("reset_ovfl", 32'(ovfl_cnt), 0);
    check("reset_sticky", ovfl_sticky, 0);
    check("reset_fsm", fsm_state, CAP_IDLE);
    cap_en = 1'b1;
    idle_bits(3);

    // nominal frame, ack three cycles after valid
    cons_mode = 0;
    ack_dly = 3;
    send_frame(16'h1234, 16'hABCD, 20, 0, 0, 0, 0);
    drain_and_check("nominal");

    // ack lands on the frame_done cycle of the second frame
    cons_mode = 1;
    send_frame(16'h1111, 16'h2222, 20, 0, 0, 0, 0);
    send_frame(16'h3333, 16'h4444, 20, 0, 0, 0, 1);
    cons_mode = 0;
    mdl_hold = 0;
    drain_and_check("coinc");

    // cap_en dropped mid left word, then a clean frame
    send_frame(16'($urandom), 16'($urandom), 20, 2, 10, 0, 0);
    send_frame(16'h7FFF, 16'h8000, 20, 0, 0, 0, 0);
    drain_and_check("enable");

    // early lrc toggle mid word, then a clean frame
    send_frame(16'($urandom), 16'($urandom), 20, 1, 9, 0, 0);
    send_frame(16'($urandom), 16'($urandom), 20, 0, 0, 0, 0);
    drain_and_check("abort");

    // 32-bit slots, padding bits all ones
    send_frame(16'hF0F0, 16'h0F0F, 32, 0, 0, 1, 0);
    drain_and_check("long_slot");

    // randomized frames, slot lengths, ack delays and aborts
    for (int i = 0; i < 10; i++) begin
      int sel;
      int kind;
      ack_dly = $urandom_range(2, 6);
      sel = $urandom_range(0, 4);
      kind = (sel == 3) ? 1 : (sel == 4) ? 2 : 0;
      send_frame(16'($urandom), 16'($urandom), $urandom_range(18, 24),
                 kind, $urandom_range(3, 17), 0, 0);
    end
    drain_and_check("random");

    // consumer stalled over three frames
    cons_mode = 1;
    send_frame(16'h0001, 16'h0002, 18, 0, 0, 0, 0);
    send_frame(16'h0003, 16'h0004, 18, 0, 0, 0, 0);
    send_frame(16'h0005, 16'h0006, 18, 0, 0, 0, 0);
    check("bp_data", pcm_if.pcm_data, 32'h0001_0002);
    check("bp_ovfl", 32'(ovfl_cnt), mdl_ovfl);
    check("bp_sticky", ovfl_sticky, 1);

    // reach five drops, then reset mid handshake inside the next frame
    for (int i = 0; i < 3; i++) send_frame(16'($urandom), 16'($urandom), 18, 0, 0, 0, 0);
    check("pre_rst_ovfl", 32'(ovfl_cnt), mdl_ovfl);
    check("pre_rst_valid", pcm_if.pcm_data_valid, 1);
    send_frame(16'($urandom), 16'($urandom), 20, 3, 8, 0, 0);
    cons_mode = 0;
    ack_dly = 2;
    send_frame(16'h5A5A, 16'hA5A5, 20, 0, 0, 0, 0);
    drain_and_check("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
